// File: rtl/hdmi_pll_lock_sequencer_pkg.sv
// Shared types and constants for the HDMI pixel-PLL reset/lock sequencer.
package hdmi_pll_pkg;

  localparam int LOL_CNT_W = 8;
  localparam int RETRY_W   = 3;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hdmi_pll_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: d -> meta -> q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_pll_lock_sequencer.sv
// Sequences the HDMI pixel PLL reset, qualifies lock, releases the video
// reset and re-sequences on loss of lock with a bounded retry budget.
module hdmi_pll_lock_sequencer
  import hdmi_pll_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic                 relock_req,
  output logic                 pll_rst,
  output logic                 sys_rst_n,
  output logic                 ready,
  output logic                 fail,
  output logic [RETRY_W-1:0]   retry_cnt,
  output logic [LOL_CNT_W-1:0] lol_count,
  output logic [2:0]           state_o
);

  localparam int CNT_MAX = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT), STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             lock_s;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             attempt_fail;
  logic             lol_event;
  logic             restart;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state logic; relock_req overrides every other transition
  always_comb begin
    next_state   = state;
    attempt_fail = 1'b0;
    lol_event    = 1'b0;
    case (state)
      ST_RST_HOLD: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          next_state = ST_WAIT_LOCK;
        end else begin
          next_state = ST_RST_HOLD;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          next_state = ST_STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end else begin
          next_state = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          lol_event  = 1'b1;
          next_state = ST_RST_HOLD;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_FAIL: begin
        next_state = ST_FAIL;
      end
      default: begin
        next_state = ST_RST_HOLD;
      end
    endcase

    if (attempt_fail) begin
      if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
        next_state = ST_FAIL;
      end else begin
        next_state = ST_RST_HOLD;
      end
    end else begin
      next_state = next_state;
    end

    if (relock_req) begin
      next_state   = ST_RST_HOLD;
      attempt_fail = 1'b0;
      lol_event    = 1'b0;
    end else begin
      lol_event = lol_event;
    end

    // A relock inside RST_HOLD is a fresh entry and must restart the count
    restart = relock_req || (next_state != state);
  end

  // State, shared counter, retry/loss-of-lock bookkeeping and output decodes
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= ST_RST_HOLD;
      cnt       <= '0;
      retry_cnt <= '0;
      lol_count <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= restart ? '0 : cnt + CNT_W'(1);

      if (relock_req) begin
        retry_cnt <= '0;
      end else if (attempt_fail && (retry_cnt != RETRY_W'(MAX_RETRIES))) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end else if ((next_state == ST_RUN) && (state != ST_RUN)) begin
        retry_cnt <= '0;
      end else begin
        retry_cnt <= retry_cnt;
      end

      if (lol_event && (lol_count != {LOL_CNT_W{1'b1}})) begin
        lol_count <= lol_count + LOL_CNT_W'(1);
      end else begin
        lol_count <= lol_count;
      end

      pll_rst   <= (next_state == ST_RST_HOLD) || (next_state == ST_FAIL);
      sys_rst_n <= (next_state == ST_RUN);
      ready     <= (next_state == ST_RUN);
      fail      <= (next_state == ST_FAIL);
    end
  end

  assign state_o = state;

endmodule
